stage3: RTL and testbench



---
 rtl/stage3.sv | 96 +++++++++
 tb/tb_stage3.sv | 113 +++++++++++
 2 files changed

// File: rtl/stage3.sv
// stage3: asin(L/magMN) in Q1.10 radians via restoring divide, 2-bit/cycle sqrt and
// the acos(x) = sqrt(1-x) * cubic(x) identity, padded to a fixed 24-cycle latency.
module stage3 (
  input  logic               clock,
  input  logic               rst,
  input  logic               enable,
  input  logic [15:0]        L,
  input  logic [15:0]        magMN,
  output logic signed [11:0] asin,
  output logic               valid
);
  localparam int FRAC_BITS = 10;
  localparam int LATENCY = 24;
  localparam int SH = 31 - FRAC_BITS;
  localparam logic [4:0] ASIN_END = 5'(LATENCY - 16);
  localparam logic [10:0] HALF_PI = 11'd1608;
  // cubic coefficients in Q16; the product with sqrt(1-x) in Q15 lands in Q31
  localparam logic signed [39:0] A0 = 40'sd102939;
  localparam logic signed [39:0] A1 = -40'sd13901;
  localparam logic signed [39:0] A2 = 40'sd4867;
  localparam logic signed [39:0] A3 = -40'sd1227;
  localparam logic signed [39:0] PI_Q31 = 40'sd3373259426;
  typedef enum logic [1:0] {IDLE, DIV, ASIN, DONE} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [15:0] den, rem, srem, srem_n, root, root_n;
  logic [13:0] q;
  logic [10:0] res, res_n;
  logic sat, ge;
  logic [16:0] shl;
  logic [31:0] rad, s1;
  logic [3:0] dig;
  logic signed [39:0] x, h1, h2, poly, diff, rnd;
  function automatic logic [31:0] sq(input logic [15:0] r, input logic [15:0] t, input logic [1:0] d);
    logic [17:0] a, b;
    a = {r, d};
    b = {t, 2'b01};
    return a >= b ? {16'(a - b), t[14:0], 1'b1} : {a[15:0], t[14:0], 1'b0};
  endfunction
  always_comb begin
    shl = {rem, 1'b0};
    ge = shl >= {1'b0, den};
    rad = {1'b0, 15'd16384 - {1'b0, q}, 16'd0};
    dig = 4'(rad >> (5'd28 - {cnt[2:0], 2'b00}));
    s1 = sq(srem, root, dig[3:2]);
    {srem_n, root_n} = sq(s1[31:16], s1[15:0], dig[1:0]);
    x = $signed({26'd0, q});
    h1 = A2 + ((A3 * x) >>> 14);
    h2 = A1 + ((h1 * x) >>> 14);
    poly = A0 + ((h2 * x) >>> 14);
    diff = PI_Q31 - poly * $signed({24'd0, root});
    rnd = (diff + (40'sd1 <<< (SH - 1))) >>> SH;
    res_n = diff[39] ? 11'd0 : rnd > 40'sd1608 ? HALF_PI : rnd[10:0];
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      asin <= '0;
      valid <= 1'b0;
      cnt <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state <= DIV;
          cnt <= '0;
          den <= magMN;
          rem <= L;
          q <= '0;
          sat <= magMN == 16'd0 || L >= magMN;
          srem <= '0;
          root <= '0;
        end
        DIV: begin
          rem <= ge ? 16'(shl - {1'b0, den}) : shl[15:0];
          q <= {q[12:0], ge};
          cnt <= cnt == 5'd13 ? 5'd0 : cnt + 5'd1;
          if (cnt == 5'd13) state <= ASIN;
        end
        ASIN: begin
          if (cnt < 5'd8) {srem, root} <= {srem_n, root_n};
          if (cnt == ASIN_END) begin
            res <= res_n;
            state <= DONE;
          end
          cnt <= cnt + 5'd1;
        end
        default: begin
          asin <= {1'b0, sat ? HALF_PI : res};
          valid <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stage3.sv
// tb_stage3: ideal real-valued asin model with spec timing, checked every cycle, plus literal pins.
module tb_stage3;
  logic clock = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [15:0] L = '0, magMN = '0;
  logic signed [11:0] asin;
  logic valid;
  int vectors = 0, errors = 0;
  int edges = 0, due = -1, pend_exp = 0, pend_tol = 0, hold_exp = 0, hold_tol = 0;
  bit pend = 1'b0, vnow = 1'b0;
  int tl [8] = '{9700, 1, 30000, 65535, 40000, 123, 20000, 65000};
  int tm [8] = '{10000, 65535, 65535, 65535, 50000, 456, 21000, 64000};

  stage3 dut (.clock(clock), .rst(rst), .enable(enable), .L(L), .magMN(magMN),
              .asin(asin), .valid(valid));

  always #5 clock = ~clock;

  function automatic void ideal(input int l, input int m, output int e, output int t);
    real r;
    if (m == 0 || l >= m) begin e = 1608; t = 0; end
    else if (l == 0) begin e = 0; t = 0; end
    else begin
      r = real'(l) / real'(m);
      e = int'($floor($asin(r) * 1024.0 + 0.5));
      t = r <= 0.95 ? 1 : 3;
    end
  endfunction

  always @(posedge clock) begin
    edges++;
    vnow = 1'b0;
    if (rst) begin
      pend = 1'b0; hold_exp = 0; hold_tol = 0;
    end else if (pend && edges == due) begin
      vnow = 1'b1; pend = 1'b0; hold_exp = pend_exp; hold_tol = pend_tol;
    end else if (!pend && enable) begin
      pend = 1'b1; due = edges + 24;
      ideal(int'(L), int'(magMN), pend_exp, pend_tol);
    end
  end

  task automatic check(input string name, input int got, input int want, input int tol);
    vectors++;
    if (got < want - tol || got > want + tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d) at edge %0d", name, got, want, tol, edges);
    end
  endtask

  always @(negedge clock) if (edges > 0) begin
    check("valid", valid === 1'b1 ? 1 : valid === 1'b0 ? 0 : 2, int'(vnow), 0);
    check("asin", int'(asin), hold_exp, hold_tol);
  end

  task automatic start(input int l, input int m);
    @(negedge clock);
    L = 16'(l); magMN = 16'(m); enable = 1'b1;
    @(negedge clock);
    enable = 1'b0; L = 16'($urandom); magMN = 16'($urandom);
  endtask

  task automatic wait_valid(output int got);
    got = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (valid === 1'b1) begin
        got = int'(asin);
        return;
      end
    end
    vectors++; errors++;
    $display("FAIL timeout: valid %b after 40 cycles, want 1", valid);
  endtask

  task automatic job(input int l, input int m, output int got);
    start(l, m);
    wait_valid(got);
  endtask

  initial begin
    int got;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    job(1166, 6087, got);   check("pin_1166_6087", got, 197, 1);
    job(0, 5000, got);      check("pin_zero", got, 0, 0);
    job(6087, 6087, got);   check("pin_equal", got, 1608, 0);
    job(9000, 100, got);    check("pin_over", got, 1608, 0);
    job(123, 0, got);       check("pin_div0", got, 1608, 0);
    job(3000, 6000, got);   check("pin_half", got, 536, 1);
    start(1000, 4000);
    repeat (4) @(negedge clock);
    L = 16'd4000; magMN = 16'd4000; enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    wait_valid(got);        check("pin_busy_kept", got, 259, 1);
    repeat (30) @(negedge clock);
    start(2000, 3000);
    repeat (8) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    repeat (30) @(negedge clock);
    check("pin_reset_clears", int'(asin), 0, 0);
    job(5000, 6000, got);   check("pin_after_reset", got, 1009, 1);
    for (int i = 0; i < 8; i++) job(tl[i], tm[i], got);
    L = 16'd2000; magMN = 16'd7000; enable = 1'b1;
    repeat (60) @(negedge clock);
    enable = 1'b0;
    repeat (30) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
